// File: rtl/hack_screen_pkg.sv
// Shared screen-buffer widths, write-FIFO entry type and arbiter slot encoding.
package hack_screen_pkg;

  localparam int unsigned SCREEN_ADDR_W = 13;
  localparam int unsigned SCREEN_DATA_W = 16;
  localparam int unsigned SCREEN_WORDS  = 8192;

  typedef struct packed {
    logic [SCREEN_ADDR_W-1:0] addr;
    logic [SCREEN_DATA_W-1:0] data;
  } scr_wr_t;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_t;

endpackage

// File: rtl/screen_wr_fifo.sv
// Synchronous CPU screen-write FIFO; also exposes its storage and read pointer
// so the arbiter can search queued entries.
module screen_wr_fifo
  import hack_screen_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  scr_wr_t               wr_entry,
  output scr_wr_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [LVL_W-1:0]      level,
  output scr_wr_t [DEPTH-1:0]   entries,
  output logic [PTR_W-1:0]      rd_ptr
);

  scr_wr_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]    wr_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/screen_arbiter.sv
// Arbitrates the single-port screen RAM between queued CPU writes and display reads.
// Optional read-after-write forwarding from the FIFO: define SCREEN_ARB_RAW_FWD_EN.
module screen_arbiter
  import hack_screen_pkg::*;
#(
  parameter int unsigned ADDR_W     = $clog2(SCREEN_WORDS),
  parameter int unsigned DATA_W     = SCREEN_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_STARVE = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_data,
  output logic                        cpu_stall,
  input  logic                        disp_req,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic                        disp_gnt,
  output logic                        disp_valid,
  output logic [DATA_W-1:0]           disp_data,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W    = PTR_W + 1;
  localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);

  slot_t                    slot;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  scr_wr_t                  fifo_head;
  scr_wr_t                  wr_entry;
  scr_wr_t [FIFO_DEPTH-1:0] fifo_entries;
  logic [PTR_W-1:0]         fifo_rd_ptr;
  logic [STARVE_W-1:0]      starve_cnt;
  logic [DATA_W-1:0]        data_q;
  logic [DATA_W-1:0]        rd_src;

  assign cpu_stall = fifo_full;
  assign wr_entry  = '{addr: SCREEN_ADDR_W'(cpu_addr), data: SCREEN_DATA_W'(cpu_data)};

  screen_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .entries  (fifo_entries),
    .rd_ptr   (fifo_rd_ptr)
  );

  // Per-cycle slot choice: reads win until the queue has starved MAX_STARVE cycles.
  always_comb begin
    slot      = SLOT_IDLE;
    push      = 1'b0;
    pop       = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    disp_gnt  = 1'b0;
    ram_addr  = disp_addr;
    ram_wdata = DATA_W'(fifo_head.data);
    if (!reset) begin
      push = cpu_we && !fifo_full;
      if (disp_req && (fifo_empty || starve_cnt < STARVE_W'(MAX_STARVE))) begin
        slot = SLOT_READ;
      end else if (!fifo_empty) begin
        slot = SLOT_WRITE;
      end
    end
    case (slot)
      SLOT_READ: begin
        ram_en   = 1'b1;
        disp_gnt = 1'b1;
      end
      SLOT_WRITE: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        pop      = 1'b1;
        ram_addr = ADDR_W'(fifo_head.addr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      overflow   <= 1'b0;
      disp_valid <= 1'b0;
      data_q     <= '0;
    end else begin
      if (pop || fifo_empty) begin
        starve_cnt <= '0;
      end else if (starve_cnt < STARVE_W'(MAX_STARVE)) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
      if (cpu_we && cpu_stall) overflow <= 1'b1;
      disp_valid <= disp_gnt;
      data_q     <= disp_data;
    end
  end

  // RAM data lands the cycle after grant; hold the last returned word otherwise.
  assign disp_data = disp_valid ? rd_src : data_q;

`ifdef SCREEN_ARB_RAW_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_hit_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [PTR_W-1:0]  fwd_idx;

  // Walk oldest to newest so the newest matching queued write wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      fwd_idx = fifo_rd_ptr + PTR_W'(i);
      if (LVL_W'(i) < fifo_level &&
          ADDR_W'(fifo_entries[fwd_idx].addr) == disp_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = DATA_W'(fifo_entries[fwd_idx].data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else if (disp_gnt) begin
      fwd_hit_q  <= fwd_hit;
      fwd_data_q <= fwd_data;
    end
  end

  assign rd_src = fwd_hit_q ? fwd_data_q : ram_rdata;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fifo_entries, fifo_rd_ptr};
  assign rd_src     = ram_rdata;
`endif

endmodule
